dpll_pi: RTL

- Parametrised all-digital PLL. Successor to the 8-bit bang-bang PLL.
- Measures the signed phase error, in system-clock cycles, between rising edges of the reference and the reconstructed clock.
- Feeds that error through a proportional-integral loop filter with separate shift gains to steer an ACC_W-bit NCO.
- Adds a lock detector and exposes the frequency word and error for scope and bench observation.

---
 rtl/dpll_pkg.sv | 16 +
 rtl/dpll_phase_meas.sv | 81 ++++++++
 rtl/dpll_pi.sv | 73 +++++++
 3 files changed

// File: rtl/dpll_pkg.sv
// dpll_pkg: shared FSM type, default widths and saturating helpers for the PI digital PLL
package dpll_pkg;
  localparam int ACC_W_DEF = 16;
  localparam int ERR_W_DEF = 8;
  localparam int LOCK_LEN_DEF = 8;
  localparam int SYNC_STAGES_DEF = 2;
  typedef enum logic [1:0] {IDLE, REF_FIRST, REC_FIRST} phase_st_e;
  function automatic logic signed [63:0] clamp_s(input logic signed [63:0] x,
                                                 input logic signed [63:0] lo,
                                                 input logic signed [63:0] hi);
    return x < lo ? lo : x > hi ? hi : x;
  endfunction
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x, input int w);
    return clamp_s(x, -(64'sd1 <<< (w - 1)), (64'sd1 <<< (w - 1)) - 64'sd1);
  endfunction
endpackage

// File: rtl/dpll_phase_meas.sv
// dpll_phase_meas: ref synchroniser, edge detectors and signed phase-error counter FSM
module dpll_phase_meas import dpll_pkg::*; #(
  parameter int ERR_W = ERR_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ref_clk_i,
  input  logic             rec_msb_i,
  output logic [ERR_W-1:0] err_o,
  output logic             err_valid_o,
  output logic             lead_o,
  output logic             open_o
);
  localparam int CW = ERR_W - 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  phase_st_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic ref_d_q, rec_d_q, err_valid_q, err_valid_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [ERR_W-1:0] err_q, err_d, pos, neg;
  logic ref_rise, rec_rise;
  assign ref_rise = sync_q[SYNC_STAGES-1] & ~ref_d_q;
  assign rec_rise = rec_msb_i & ~rec_d_q;
  assign cnt_inc = cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1;
  assign pos = {1'b0, cnt_q};
  assign neg = -pos;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      ref_d_q <= 1'b0;
      rec_d_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= '0;
      err_valid_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ref_clk_i};
      ref_d_q <= sync_q[SYNC_STAGES-1];
      rec_d_q <= rec_msb_i;
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      err_valid_q <= err_valid_d;
    end
  end
  // a coincident pair of edges closes the open measurement and opens the opposite one
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_inc;
    err_d = err_q;
    err_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = CW'(1);
        state_d = ref_rise && !rec_rise ? REF_FIRST : rec_rise && !ref_rise ? REC_FIRST : IDLE;
        err_valid_d = ref_rise & rec_rise;
        err_d = ref_rise && rec_rise ? '0 : err_q;
      end
      REF_FIRST: begin
        cnt_d = rec_rise || ref_rise ? CW'(1) : cnt_inc;
        state_d = rec_rise ? (ref_rise ? REC_FIRST : IDLE) : REF_FIRST;
        err_valid_d = rec_rise;
        err_d = rec_rise ? pos : err_q;
      end
      REC_FIRST: begin
        cnt_d = rec_rise || ref_rise ? CW'(1) : cnt_inc;
        state_d = ref_rise ? (rec_rise ? REF_FIRST : IDLE) : REC_FIRST;
        err_valid_d = ref_rise;
        err_d = ref_rise ? neg : err_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    lead_o = state_q == REC_FIRST;
    open_o = state_q != IDLE;
    err_o = err_q;
    err_valid_o = err_valid_q;
  end
endmodule

// File: rtl/dpll_pi.sv
// dpll_pi: digital PLL with PI loop filter, NCO and lock detector
module dpll_pi import dpll_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF,
  parameter int ERR_W = ERR_W_DEF,
  parameter int LOCK_LEN = LOCK_LEN_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             i_sys_clk,
  input  logic             i_rst,
  input  logic             i_ref_clk,
  input  logic [ACC_W-1:0] i_freq_step,
  input  logic [2:0]       i_kp,
  input  logic [2:0]       i_ki,
  input  logic [ERR_W-2:0] i_lock_thresh,
  output logic             o_rec_clk,
  output logic             o_lead_or_lag,
  output logic             o_phase_error,
  output logic [ERR_W-1:0] o_err,
  output logic             o_err_valid,
  output logic [ACC_W-1:0] o_freq_word,
  output logic             o_locked
);
  localparam int FW = ACC_W + 2;
  localparam int LW = $clog2(LOCK_LEN + 1);
  logic [ACC_W-1:0] acc_q, freq_q, freq_d;
  logic signed [ACC_W-1:0] integ_q, integ_d;
  logic signed [FW-1:0] prop_q, prop_d, e, sum;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [ERR_W-1:0] err_abs;
  logic locked_q, in_th;
  dpll_phase_meas #(.ERR_W(ERR_W), .SYNC_STAGES(SYNC_STAGES)) u_meas (
    .clk_i(i_sys_clk),
    .rst_i(i_rst),
    .ref_clk_i(i_ref_clk),
    .rec_msb_i(acc_q[ACC_W-1]),
    .err_o(o_err),
    .err_valid_o(o_err_valid),
    .lead_o(o_lead_or_lag),
    .open_o(o_phase_error)
  );
  always_comb begin
    e = {{(FW-ERR_W){o_err[ERR_W-1]}}, o_err};
    prop_d = o_err_valid ? e >>> i_kp : prop_q;
    integ_d = o_err_valid ? ACC_W'(sat_s(64'(integ_q) + 64'(e >>> i_ki), ACC_W)) : integ_q;
    sum = signed'({2'b00, i_freq_step}) + FW'(integ_q) + prop_q;
    freq_d = ACC_W'(clamp_s(64'(sum), 64'sd1, (64'sd1 <<< ACC_W) - 64'sd1));
    err_abs = o_err[ERR_W-1] ? -o_err : o_err;
    in_th = err_abs <= {1'b0, i_lock_thresh};
    lock_cnt_d = !o_err_valid ? lock_cnt_q : !in_th ? '0 :
                 lock_cnt_q == LW'(LOCK_LEN) ? lock_cnt_q : lock_cnt_q + 1'b1;
  end
  // lock flag follows the next count so a bad error drops it one cycle after the pulse
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      acc_q <= '0;
      freq_q <= '0;
      integ_q <= '0;
      prop_q <= '0;
      lock_cnt_q <= '0;
      locked_q <= 1'b0;
    end else begin
      acc_q <= acc_q + freq_q;
      freq_q <= freq_d;
      integ_q <= integ_d;
      prop_q <= prop_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q <= lock_cnt_d == LW'(LOCK_LEN);
    end
  end
  assign o_rec_clk = acc_q[ACC_W-1];
  assign o_freq_word = freq_q;
  assign o_locked = locked_q;
endmodule
